alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle RV32I ALU. It executes the base integer ALU operations and an unsigned multiply/divide subset from the RV32M extension. Operands are captured on a valid/ready input handshake. Results are returned on a valid/ready output handshake. It sits in the execute stage of the multi-cycle core, between operand muxes and writeback.

---
 rtl/alu_mc.sv | 139 +++++++++++++
 tb/tb_alu_mc.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle RV32I ALU with unsigned RV32M multiply/divide subset.
// Operands and results move on valid/ready handshakes.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] alu_y, it_y;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   madd, msum, shl, dif;
  logic             acc, iter, last, is_mul;

  assign acc    = in_valid && in_ready;
  assign iter   = (ALUControl >= 4'hA) && (ALUControl <= 4'hD);
  assign last   = (cnt == CW'(1));
  assign is_mul = (op_q[3:1] == 3'b101);
  assign shamt  = b[SW-1:0];

  always_comb begin
    alu_y = '0;
    case (ALUControl)
      4'h0: alu_y = a + b;
      4'h1: alu_y = a - b;
      4'h2: alu_y = a & b;
      4'h3: alu_y = a | b;
      4'h4: alu_y = a ^ b;
      4'h5: alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'h6: alu_y = {{(WIDTH-1){1'b0}}, a < b};
      4'h7: alu_y = a << shamt;
      4'h8: alu_y = a >> shamt;
      4'h9: alu_y = WIDTH'($signed(a) >>> shamt);
      default: alu_y = '0;
    endcase
  end

  // hi:lo is the product for multiply, remainder:quotient for divide
  always_comb begin
    madd = {1'b0, hi} + {1'b0, a_q};
    msum = lo[0] ? madd : {1'b0, hi};
    shl  = {hi, lo[WIDTH-1]};
    dif  = shl - {1'b0, b_q};
    hi_n = '0;
    lo_n = '0;
    if (is_mul) begin
      {hi_n, lo_n} = {msum, lo[WIDTH-1:1]};
    end else if (!dif[WIDTH]) begin
      hi_n = dif[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = shl[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], 1'b0};
    end
    it_y = op_q[0] ? hi_n : lo_n;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = iter ? BUSY : DONE;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      y    <= '0;
      zero <= 1'b1;
    end else if (acc) begin
      op_q <= ALUControl;
      a_q  <= a;
      b_q  <= b;
      if (iter) begin
        cnt <= CW'(WIDTH);
        hi  <= '0;
        lo  <= ALUControl[2] ? a : b;
      end else begin
        y    <= alu_y;
        zero <= (alu_y == '0);
      end
    end else if (state == BUSY) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
      if (last) begin
        y    <= it_y;
        zero <= (it_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed plan vectors plus
// random ops against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic [3:0]   ctl = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic         zero;

  int nvec = 0;
  int nerr = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(opa),
    .b(opb),
    .ALUControl(ctl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
    .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] z);
    logic [2*W-1:0] p;
    int sh;
    p  = {{W{1'b0}}, x} * {{W{1'b0}}, z};
    sh = int'(z % W);
    case (op)
      4'd0:  return x + z;
      4'd1:  return x - z;
      4'd2:  return x & z;
      4'd3:  return x | z;
      4'd4:  return x ^ z;
      4'd5:  return ($signed(x) < $signed(z)) ? 1 : 0;
      4'd6:  return (x < z) ? 1 : 0;
      4'd7:  return x << sh;
      4'd8:  return x >> sh;
      4'd9:  return W'($signed(x) >>> sh);
      4'd10: return p[W-1:0];
      4'd11: return p[2*W-1:W];
      4'd12: return (z == 0) ? '1 : x / z;
      4'd13: return (z == 0) ? x : x % z;
      default: return '0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int hold,
                        input bit pulse);
    logic [W-1:0] exp;
    int explat, lat;
    exp    = ref_alu(op, av, bv);
    explat = (op >= 4'd10 && op <= 4'd13) ? W + 1 : 1;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_pre", {31'b0, in_ready}, 1);
    in_valid = 1'b1;
    opa = av;
    opb = bv;
    ctl = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opa = $urandom;
    opb = $urandom;
    ctl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      chk("busy_in_ready", {31'b0, in_ready}, 0);
      if (pulse) in_valid = lat[0];
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", W'(lat), W'(explat));
    chk("y", y, exp);
    chk("zero", {31'b0, zero}, {31'b0, exp == '0});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_y", y, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_in_ready", {31'b0, in_ready}, 1);
    chk("post_valid", {31'b0, out_valid}, 0);
    chk("post_y_kept", y, exp);
  endtask

  initial begin
    int seen;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", {31'b0, zero}, 1);

    run_op(4'd0, 32'hFFFFFFFB, 32'd3, 0, 0);
    run_op(4'd1, 32'hFFFFFFFB, 32'd3, 0, 0);
    run_op(4'd5, 32'hFFFFFFFB, 32'd3, 0, 0);
    run_op(4'd6, 32'hFFFFFFFB, 32'd3, 0, 0);
    run_op(4'd9, 32'h80000000, 32'd33, 0, 0);
    run_op(4'd7, 32'd1, 32'd31, 0, 0);
    run_op(4'd1, 32'd7, 32'd7, 0, 0);
    run_op(4'd10, 32'hFFFFFFFF, 32'd2, 0, 1);
    run_op(4'd11, 32'hFFFFFFFF, 32'd2, 0, 1);
    run_op(4'd12, 32'd100, 32'd7, 0, 0);
    run_op(4'd13, 32'd100, 32'd7, 0, 0);
    run_op(4'd12, 32'h1234, 32'd0, 0, 0);
    run_op(4'd13, 32'h1234, 32'd0, 0, 0);
    run_op(4'd3, 32'hF0, 32'h0F, 5, 0);
    run_op(4'd14, 32'h55, 32'hAA, 0, 0);

    in_valid = 1'b1;
    opa = 32'hFFFFFFFF;
    opb = 32'd2;
    ctl = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b1;
    ctl = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    chk("abort_in_ready", {31'b0, in_ready}, 1);
    chk("abort_valid", {31'b0, out_valid}, 0);
    chk("abort_y", y, 0);
    chk("abort_zero", {31'b0, zero}, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_valid", W'(seen), 0);
    run_op(4'd0, 32'd2, 32'd2, 0, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      if (rop == 4'd5 && n[0]) rb = ra;
      run_op(rop, ra, rb, $urandom_range(0, 2), n[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
